// File: rtl/draw_sprite_layers.sv
// draw_sprite_layers: overlays N_SPR prioritised sprites (index 0 on top)
// on the video stream, 2-cycle latency, per-frame position latch and
// collision flag. Ports: timing/counts/rgb in and out, xpos/ypos/visible,
// per-sprite ROM pixel_addr/rgb_pixel, collision.
// Optional colour-key transparency: define SPRITE_TRANSPARENCY_EN.
module draw_sprite_layers #(
  parameter int          N_SPR     = 2,
  parameter int          SPR_W     = 64,
  parameter int          SPR_H     = 64,
  parameter int          ADDR_W    = 12,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic                    pclk,
  input  logic                    rst_n,
  input  logic [10:0]             hcount_in,
  input  logic [10:0]             vcount_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    hblnk_in,
  input  logic                    vblnk_in,
  input  logic [11:0]             rgb_in,
  input  logic [11*N_SPR-1:0]     xpos,
  input  logic [11*N_SPR-1:0]     ypos,
  input  logic [N_SPR-1:0]        visible,
  input  logic [12*N_SPR-1:0]     rgb_pixel,
  output logic [ADDR_W*N_SPR-1:0] pixel_addr,
  output logic [10:0]             hcount_out,
  output logic [10:0]             vcount_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    hblnk_out,
  output logic                    vblnk_out,
  output logic [11:0]             rgb_out,
  output logic                    collision
);

  localparam int LW = $clog2(SPR_W);
  localparam int LH = $clog2(SPR_H);

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic [N_SPR-1:0][10:0] x_in, y_in;
  logic [N_SPR-1:0][10:0] x_l, y_l;
  logic [N_SPR-1:0][10:0] x_e, y_e;
  logic [N_SPR-1:0]       vis_l, vis_e;
  logic [N_SPR-1:0][11:0] pix;

  assign x_in = xpos;
  assign y_in = ypos;
  assign pix  = rgb_pixel;

  logic frame_start;
  assign frame_start = (hcount_in == 11'd0)
                    && (vcount_in == 11'd0);

  // The frame-start pixel already uses the freshly sampled positions.
  always_comb begin
    x_e   = frame_start ? x_in : x_l;
    y_e   = frame_start ? y_in : y_l;
    vis_e = frame_start ? visible : vis_l;
  end

  logic [N_SPR-1:0]              hit;
  logic [N_SPR-1:0][LW-1:0]      dx;
  logic [N_SPR-1:0][LH-1:0]      dy;
  logic [N_SPR-1:0][ADDR_W-1:0]  addr_d;

  // 12-bit compares so x+SPR_W near 2047 cannot wrap to column 0.
  always_comb begin
    for (int i = 0; i < N_SPR; i++) begin
      dx[i] = hcount_in[LW-1:0] - x_e[i][LW-1:0];
      dy[i] = vcount_in[LH-1:0] - y_e[i][LH-1:0];
      hit[i] = vis_e[i]
        && ({1'b0, hcount_in} >= {1'b0, x_e[i]})
        && ({1'b0, hcount_in} <
            ({1'b0, x_e[i]} + 12'(SPR_W)))
        && ({1'b0, vcount_in} >= {1'b0, y_e[i]})
        && ({1'b0, vcount_in} <
            ({1'b0, y_e[i]} + 12'(SPR_H)));
      addr_d[i] = hit[i] ? ADDR_W'({dy[i], dx[i]}) : '0;
    end
  end

  logic [10:0]      s1_h, s1_v;
  logic             s1_hs, s1_vs, s1_hb, s1_vb;
  logic [11:0]      s1_rgb;
  logic [N_SPR-1:0] s1_hit;

  logic [N_SPR-1:0] opaque;
  logic [2:0]       n_op;
  logic [11:0]      rgb_d;
  logic             blank;
  logic             multi;

  // Descending scan lets the lowest-index opaque sprite win.
  always_comb begin
    rgb_d = s1_rgb;
    n_op  = '0;
    for (int i = N_SPR-1; i >= 0; i--) begin
      opaque[i] = s1_hit[i]
        && !(KEY_EN && (pix[i] == KEY_COLOR));
      if (opaque[i]) rgb_d = pix[i];
      n_op = n_op + 3'(opaque[i]);
    end
    blank = s1_hb || s1_vb;
    if (blank) rgb_d = '0;
    multi = !blank && (n_op >= 3'd2);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_l        <= '0;
      y_l        <= '0;
      vis_l      <= '0;
      pixel_addr <= '0;
      s1_h       <= '0;
      s1_v       <= '0;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
      s1_hb      <= 1'b0;
      s1_vb      <= 1'b0;
      s1_rgb     <= '0;
      s1_hit     <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      if (frame_start) begin
        x_l   <= x_in;
        y_l   <= y_in;
        vis_l <= visible;
      end
      pixel_addr <= addr_d;
      s1_h       <= hcount_in;
      s1_v       <= vcount_in;
      s1_hs      <= hsync_in;
      s1_vs      <= vsync_in;
      s1_hb      <= hblnk_in;
      s1_vb      <= vblnk_in;
      s1_rgb     <= rgb_in;
      s1_hit     <= hit;
      hcount_out <= s1_h;
      vcount_out <= s1_v;
      hsync_out  <= s1_hs;
      vsync_out  <= s1_vs;
      hblnk_out  <= s1_hb;
      vblnk_out  <= s1_vb;
      rgb_out    <= rgb_d;
    end
  end

  // Pixel still in stage 2 at frame start belongs to the old frame.
  logic flag;
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      flag      <= 1'b0;
      collision <= 1'b0;
    end else if (frame_start) begin
      collision <= flag | multi;
      flag      <= 1'b0;
    end else if (multi) begin
      flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_draw_sprite_layers.sv
// tb_draw_sprite_layers: vector table, hand sequences and randomized
// frames checked against a pixel-level reference model.
module tb_draw_sprite_layers;

  localparam int N = 2;

  logic          pclk = 1'b0;
  logic          rst_n;
  logic [10:0]   hcount_in, vcount_in;
  logic          hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0]   rgb_in;
  logic [21:0]   xpos, ypos;
  logic [1:0]    visible;
  logic [23:0]   rgb_pixel;
  logic [23:0]   pixel_addr;
  logic [10:0]   hcount_out, vcount_out;
  logic          hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]   rgb_out;
  logic          collision;

  always #5 pclk = ~pclk;

  logic [11:0] rom0 [4096];
  logic [11:0] rom1 [4096];

  assign rgb_pixel = {rom1[pixel_addr[23:12]],
                      rom0[pixel_addr[11:0]]};

  draw_sprite_layers dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .visible(visible), .rgb_pixel(rgb_pixel),
    .pixel_addr(pixel_addr),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .collision(collision)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference model state: frame positions and collision.
  int fx[N], fy[N];
  bit fv[N];
  int frame_n;
  bit coll_m;

  typedef struct {
    logic [10:0] h, v;
    logic hs, vs, hb, vb;
    logic [11:0] rgb;
  } exp_t;
  exp_t q[$];

  function automatic void model(input int h, input int v,
                                output logic [11:0] c,
                                output int n,
                                output logic [23:0] ad);
    logic [11:0] px;
    int a;
    bit op, got;
    c = '0; n = 0; ad = '0; got = 0;
    for (int i = 0; i < N; i++) begin
      if (fv[i] && h >= fx[i] && h < fx[i] + 64
          && v >= fy[i] && v < fy[i] + 64) begin
        a = (v - fy[i]) * 64 + (h - fx[i]);
        ad[12*i +: 12] = 12'(a);
        px = (i == 0) ? rom0[a] : rom1[a];
`ifdef SPRITE_TRANSPARENCY_EN
        op = (px != 12'hF0F);
`else
        op = 1'b1;
`endif
        if (op) begin
          n++;
          if (!got) begin
            c = px;
            got = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      fx[i] = 0; fy[i] = 0; fv[i] = 1'b0;
    end
    frame_n = 0;
    coll_m  = 1'b0;
    q.delete();
  endtask

  task automatic cyc(input int h, input int v,
                     input logic [11:0] bg);
    exp_t e;
    logic [11:0] c;
    int n;
    logic [23:0] ad;
    bit blk;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    rgb_in    = bg;
    hblnk_in  = (h >= 1024);
    vblnk_in  = (v >= 768);
    hsync_in  = (h >= 1048 && h < 1184);
    vsync_in  = (v >= 771 && v < 777);
    if (h == 0 && v == 0) begin
      for (int i = 0; i < N; i++) begin
        fx[i] = int'(xpos[11*i +: 11]);
        fy[i] = int'(ypos[11*i +: 11]);
        fv[i] = visible[i];
      end
      coll_m  = (frame_n > 0);
      frame_n = 0;
    end
    model(h, v, c, n, ad);
    blk = (h >= 1024) || (v >= 768);
    if (n >= 2 && !blk) frame_n++;
    e.h  = 11'(h);
    e.v  = 11'(v);
    e.hs = hsync_in;
    e.vs = vsync_in;
    e.hb = hblnk_in;
    e.vb = vblnk_in;
    e.rgb = blk ? 12'h000 : ((n > 0) ? c : bg);
    q.push_back(e);
    @(posedge pclk);
    #1;
    chk("pixel_addr", 64'(pixel_addr), 64'(ad));
    if (q.size() == 2) begin
      chk("rgb_out", 64'(rgb_out), 64'(q[0].rgb));
      chk("timing",
          64'({hcount_out, vcount_out, hsync_out,
               vsync_out, hblnk_out, vblnk_out}),
          64'({q[0].h, q[0].v, q[0].hs,
               q[0].vs, q[0].hb, q[0].vb}));
      q.delete(0);
    end
    chk("collision", 64'(collision), 64'(coll_m));
  endtask

  typedef struct {
    bit          fs;
    int          x0, y0, x1, y1;
    logic [1:0]  vis;
    int          h, v;
    logic [11:0] bg, rgb;
    logic [23:0] addr;
    int          coll;
  } vec_t;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam logic [11:0] T_RGB  = 12'hF4E;
  localparam int          T_COLL = 0;
`else
  localparam logic [11:0] T_RGB  = 12'hF0F;
  localparam int          T_COLL = 1;
`endif

  localparam int NV = 25;
  vec_t tv[NV];

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  int px[2], py[2];

  initial begin
    rst_n = 1'b0;
    hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = '0; xpos = '0; ypos = '0; visible = '0;
    for (int a = 0; a < 4096; a++) begin
      rom0[a] = 12'(a);
      rom1[a] = 12'(a) ^ 12'hA5A;
    end
    rom0[1300] = 12'hF0F;
    model_reset();

    // sprite at (100,200)
    tv[0]  = '{1,100,200,0,0,2'b01,163,263,12'h123,12'hFFF,24'h000FFF,-1};
    tv[1]  = '{0,100,200,0,0,2'b01,164,263,12'h123,12'h123,24'h0,-1};
    tv[2]  = '{0,100,200,0,0,2'b01,100,200,12'h456,12'h000,24'h0,-1};
    tv[3]  = '{0,100,200,0,0,2'b01,99,200,12'h456,12'h456,24'h0,-1};
    tv[4]  = '{0,100,200,0,0,2'b01,101,201,12'h456,12'h041,24'h041,-1};
    tv[5]  = '{0,100,200,0,0,2'b01,100,263,12'h456,12'hFC0,24'hFC0,-1};
    tv[6]  = '{0,100,200,0,0,2'b01,163,264,12'h789,12'h789,24'h0,-1};
    // priority and collision
    tv[7]  = '{1,300,300,300,300,2'b11,310,310,12'h111,12'h28A,24'h28A28A,-1};
    tv[8]  = '{0,300,300,300,300,2'b11,363,363,12'h111,12'hFFF,24'hFFFFFF,-1};
    tv[9]  = '{1,300,300,300,300,2'b10,310,310,12'h111,12'h8D0,24'h28A000,1};
    tv[10] = '{1,300,300,300,300,2'b10,320,300,12'h111,12'hA4E,24'h014000,0};
    // colour key
    tv[11] = '{1,500,500,500,500,2'b11,520,520,12'h222,T_RGB,24'h514514,-1};
    tv[12] = '{1,500,500,500,500,2'b11,600,600,12'h333,12'h333,24'h0,T_COLL};
    // position latch
    tv[13] = '{1,100,350,0,0,2'b01,110,384,12'h444,12'h88A,24'h88A,0};
    tv[14] = '{0,400,350,0,0,2'b01,110,384,12'h444,12'h88A,24'h88A,-1};
    tv[15] = '{0,400,350,0,0,2'b01,410,384,12'h444,12'h444,24'h0,-1};
    tv[16] = '{1,400,350,0,0,2'b01,410,384,12'h444,12'h88A,24'h88A,-1};
    tv[17] = '{0,400,350,0,0,2'b01,110,384,12'h444,12'h444,24'h0,-1};
    // clipping, blanking, no wrap
    tv[18] = '{1,1000,10,0,0,2'b01,1023,20,12'h555,12'h297,24'h297,-1};
    tv[19] = '{0,1000,10,0,0,2'b01,1024,20,12'h555,12'h000,24'h298,-1};
    tv[20] = '{0,1000,10,0,0,2'b01,0,20,12'h555,12'h555,24'h0,-1};
    tv[21] = '{0,1000,10,0,0,2'b01,1063,20,12'h555,12'h000,24'h2BF,-1};
    tv[22] = '{1,2040,10,0,0,2'b01,5,20,12'h555,12'h555,24'h0,-1};
    tv[23] = '{0,2040,10,0,0,2'b01,2045,20,12'h555,12'h000,24'h285,-1};
    tv[24] = '{1,100,740,0,0,2'b01,110,770,12'h666,12'h000,24'h78A,-1};

    repeat (3) @(posedge pclk);
    #1;
    chk("rst_rgb", 64'(rgb_out), 64'(0));
    chk("rst_timing",
        64'({hcount_out, vcount_out, hsync_out,
             vsync_out, hblnk_out, vblnk_out}), 64'(0));
    chk("rst_addr", 64'(pixel_addr), 64'(0));
    chk("rst_coll", 64'(collision), 64'(0));
    @(negedge pclk);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      xpos    = {11'(tv[k].x1), 11'(tv[k].x0)};
      ypos    = {11'(tv[k].y1), 11'(tv[k].y0)};
      visible = tv[k].vis;
      if (tv[k].fs) cyc(0, 0, 12'h0AB);
      cyc(tv[k].h, tv[k].v, tv[k].bg);
      chk($sformatf("vec%0d_addr", k),
          64'(pixel_addr), 64'(tv[k].addr));
      cyc(1200, tv[k].v, 12'h0CD);
      chk($sformatf("vec%0d_rgb", k),
          64'(rgb_out), 64'(tv[k].rgb));
      if (tv[k].coll >= 0)
        chk($sformatf("vec%0d_coll", k),
            64'(collision), 64'(tv[k].coll));
    end

    for (int a = 0; a < 4096; a++) begin
      rom0[a] = ($urandom_range(0, 7) == 0)
              ? 12'hF0F : 12'($urandom);
      rom1[a] = ($urandom_range(0, 7) == 0)
              ? 12'hF0F : 12'($urandom);
    end

    for (int f = 0; f < 10; f++) begin
      px[0] = $urandom_range(0, 1100);
      py[0] = $urandom_range(0, 780);
      if (f == 3) px[0] = 2030;
      if ($urandom_range(0, 1) == 1) begin
        px[1] = imax(0, px[0] + $urandom_range(0, 60) - 30);
        py[1] = imax(0, py[0] + $urandom_range(0, 60) - 30);
      end else begin
        px[1] = $urandom_range(0, 1100);
        py[1] = $urandom_range(0, 780);
      end
      xpos = {11'(px[1]), 11'(px[0])};
      ypos = {11'(py[1]), 11'(py[0])};
      visible = (f < 6) ? 2'b11 : 2'($urandom_range(0, 3));
      cyc(0, 0, 12'($urandom));
      for (int s = 0; s < 2; s++) begin
        for (int r = 0; r < 6; r++) begin
          int v;
          v = imax(0, py[s] - 2 + $urandom_range(0, 69));
          for (int h = imax(0, px[s] - 4);
               h <= imin(2047, px[s] + 68); h++) begin
            if ($urandom_range(0, 15) == 0)
              xpos[10:0] = 11'($urandom);
            cyc(h, v, 12'($urandom));
          end
        end
      end
    end
    cyc(0, 0, 12'h010);
    cyc(5, 5, 12'h020);

    // asynchronous reset in the middle of a line
    hcount_in = 11'd1100;
    vcount_in = 11'd300;
    hsync_in  = 1'b1;
    hblnk_in  = 1'b1;
    rgb_in    = 12'h777;
    @(posedge pclk);
    @(posedge pclk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out",
        64'({rgb_out, hcount_out, vcount_out, hsync_out,
             vsync_out, hblnk_out, vblnk_out}), 64'(0));
    chk("async_rst_addr", 64'(pixel_addr), 64'(0));
    chk("async_rst_coll", 64'(collision), 64'(0));
    @(negedge pclk);
    rst_n = 1'b1;
    model_reset();
    xpos = {11'd0, 11'd50};
    ypos = {11'd0, 11'd5};
    visible = 2'b01;
    for (int h = 1100; h < 1110; h++) cyc(h, 300, 12'h777);
    cyc(60, 10, 12'h321);
    cyc(0, 0, 12'h321);
    for (int h = 48; h < 56; h++) cyc(h, 10, 12'h321);
    cyc(1200, 10, 12'h0);
    cyc(1201, 10, 12'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
